conv_window_ctrl: RTL

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/window_addr_gen.sv | 101 ++++++++++
 rtl/conv_window_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the convolution window controller.
package cnn_pkg;

    localparam int unsigned IMG_W_DEF   = 28;
    localparam int unsigned K_DEF       = 3;
    localparam int unsigned OUT_W_DEF   = IMG_W_DEF - K_DEF + 1;
    localparam int unsigned ADDR_W_DEF  = 10;
    localparam int unsigned WADDR_W_DEF = 4;

    // Controller sequence: one window is CLR, K*K x MAC, DRAIN, WRITE.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClr   = 3'd1,
        StMac   = 3'd2,
        StDrain = 3'd3,
        StWrite = 3'd4,
        StDone  = 3'd5
    } state_e;

    // Valid (no-padding) output width for a square image and kernel.
    function automatic int unsigned out_w(input int unsigned img_w, input int unsigned k);
        return img_w - k + 1;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window/tap counters and memory address generation for conv_window_ctrl.
module window_addr_gen
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W   = IMG_W_DEF,
    parameter int unsigned K       = K_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned WADDR_W = WADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               win_clr_i,   // restart at window (0,0)
    input  logic               tap_clr_i,   // restart at tap (0,0)
    input  logic               tap_adv_i,   // step to next tap, kc fastest
    input  logic               win_adv_i,   // step to next window, col fastest
    input  logic               addr_en_i,   // drive image/weight addresses
    input  logic               out_en_i,    // drive output address
    output logic [ADDR_W-1:0]  img_addr_o,
    output logic [WADDR_W-1:0] wgt_addr_o,
    output logic [ADDR_W-1:0]  out_addr_o,
    output logic               last_tap_o,
    output logic               last_win_o
);

    localparam int unsigned        OUT_W    = out_w(IMG_W, K);
    localparam logic [ADDR_W-1:0]  OutLast  = ADDR_W'(OUT_W - 1);
    localparam logic [WADDR_W-1:0] KLast    = WADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0]  ImgWidth = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]  OutWidth = ADDR_W'(OUT_W);
    localparam logic [WADDR_W-1:0] KWidth   = WADDR_W'(K);

    logic [ADDR_W-1:0]  row_q, row_d, col_q, col_d;
    logic [WADDR_W-1:0] kr_q, kr_d, kc_q, kc_d;

    logic [ADDR_W-1:0]  pix_row, pix_col, img_lin, out_lin;
    logic [WADDR_W-1:0] wgt_lin;

    // Tap counter next state: kc wraps into kr, kr wraps to 0 after the last tap.
    always_comb begin
        kr_d = kr_q;
        kc_d = kc_q;
        if (tap_clr_i) begin
            kr_d = '0;
            kc_d = '0;
        end else if (tap_adv_i) begin
            if (kc_q == KLast) begin
                kc_d = '0;
                kr_d = (kr_q == KLast) ? '0 : kr_q + 1'b1;
            end else begin
                kc_d = kc_q + 1'b1;
            end
        end
    end

    // Window counter next state: col wraps into row, row wraps after the last window.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (win_clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (win_adv_i) begin
            if (col_q == OutLast) begin
                col_d = '0;
                row_d = (row_q == OutLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counter registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            kr_q  <= '0;
            kc_q  <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            kr_q  <= kr_d;
            kc_q  <= kc_d;
        end
    end

    // Linear addresses, unsigned at bus width; gated to zero when not being issued.
    always_comb begin
        pix_row    = row_q + ADDR_W'(kr_q);
        pix_col    = col_q + ADDR_W'(kc_q);
        img_lin    = pix_row * ImgWidth + pix_col;
        out_lin    = row_q * OutWidth + col_q;
        wgt_lin    = kr_q * KWidth + kc_q;
        img_addr_o = addr_en_i ? img_lin : '0;
        wgt_addr_o = addr_en_i ? wgt_lin : '0;
        out_addr_o = out_en_i ? out_lin : '0;
        last_tap_o = (kr_q == KLast) && (kc_q == KLast);
        last_win_o = (row_q == OutLast) && (col_q == OutLast);
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for a valid-mode KxK convolution pass over a square image.
// Issues one tap address per cycle; acc_ld trails the address by one cycle
// to match the one-cycle read latency of the image and weight memories.
module conv_window_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W   = IMG_W_DEF,
    parameter int unsigned K       = K_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned WADDR_W = WADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    output logic [ADDR_W-1:0]  img_addr,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               acc_clr,
    output logic               acc_ld,
    output logic               out_ld,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               done
);

    state_e state_q, state_d;
    logic   acc_ld_q;

    logic win_clr, tap_clr, tap_adv, win_adv, addr_en, out_en;
    logic last_tap, last_win;

    // Next-state and strobe decode; start is only looked at in StIdle.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        acc_clr = 1'b0;
        out_ld  = 1'b0;
        done    = 1'b0;
        win_clr = 1'b0;
        tap_clr = 1'b0;
        tap_adv = 1'b0;
        win_adv = 1'b0;
        addr_en = 1'b0;
        out_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    win_clr = 1'b1;
                    state_d = StClr;
                end
            end
            StClr: begin
                acc_clr = 1'b1;
                tap_clr = 1'b1;
                state_d = StMac;
            end
            StMac: begin
                addr_en = 1'b1;
                tap_adv = 1'b1;
                if (last_tap) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Final tap's data arrives here; acc_ld_q covers it.
                state_d = StWrite;
            end
            StWrite: begin
                out_ld  = 1'b1;
                out_en  = 1'b1;
                win_adv = 1'b1;
                state_d = last_win ? StDone : StClr;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register and the delayed tap-issue strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_ld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_ld_q <= (state_q == StMac);
        end
    end

    assign acc_ld = acc_ld_q;

    window_addr_gen #(
        .IMG_W   (IMG_W),
        .K       (K),
        .ADDR_W  (ADDR_W),
        .WADDR_W (WADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .win_clr_i  (win_clr),
        .tap_clr_i  (tap_clr),
        .tap_adv_i  (tap_adv),
        .win_adv_i  (win_adv),
        .addr_en_i  (addr_en),
        .out_en_i   (out_en),
        .img_addr_o (img_addr),
        .wgt_addr_o (wgt_addr),
        .out_addr_o (out_addr),
        .last_tap_o (last_tap),
        .last_win_o (last_win)
    );

endmodule
